lsu_bus_ctrl: RTL and testbench

Load/store bus controller for the core's MEM stage: accepts one load or store per handshake, converts it to word-aligned data-bus transactions with byte enables, and splits boundary-crossing halfword/word accesses into two beats. Load results return right-justified with unused upper bytes zeroed, ready for the load modifier to sign- or zero-extend. It sits between the MEM-stage pipeline register and the data memory port and holds the pipeline stalled while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_bus_ctrl_if.sv | 37 +++
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/lsu_bus_ctrl.sv | 135 +++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store bus controller.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } state_t;

    typedef logic [1:0] size_t;

    localparam size_t SZ_B = 2'd0;
    localparam size_t SZ_H = 2'd1;
    localparam size_t SZ_W = 2'd2;

    function automatic logic [2:0] size_bytes(input size_t sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // An access needs a second beat when its last byte falls into the next word.
    function automatic logic is_split(input size_t sz, input logic [1:0] off);
        return ({2'b00, off} + {1'b0, size_bytes(sz)}) > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Pipeline-side request/response and data-bus signals of the load/store controller.
interface lsu_bus_ctrl_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_lb;
    logic              req_lh;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              stall;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output req_valid, req_we, req_lb, req_lh, req_addr, req_wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  req_ready, rsp_valid, rsp_data, stall,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        input  req_valid, req_we, req_lb, req_lh, req_addr, req_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output req_ready, rsp_valid, rsp_data, stall,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: per-beat byte enables and write data, plus load merge and size mask.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  off,
    input  logic        beat,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [3:0]  size_mask;
    logic [31:0] data_mask;
    logic [4:0]  lo_shift;
    logic [5:0]  hi_shift;

    // Beat 1 carries the bytes that spilled past the word boundary of beat 0.
    always_comb begin
        size_mask = 4'b1111;
        data_mask = 32'hFFFF_FFFF;
        case (size)
            SZ_B: begin
                size_mask = 4'b0001;
                data_mask = 32'h0000_00FF;
            end
            SZ_H: begin
                size_mask = 4'b0011;
                data_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase

        lo_shift = {off, 3'b000};
        hi_shift = 6'd32 - {1'b0, lo_shift};

        if (beat) begin
            be         = size_mask >> (3'd4 - {1'b0, off});
            wdata_lane = wdata >> hi_shift;
        end else begin
            be         = size_mask << off;
            wdata_lane = wdata << lo_shift;
        end

        load_data = ((rdata0 >> lo_shift) | (rdata1 << hi_shift)) & data_mask;
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// MEM-stage load/store controller: one access at a time, split into at most two
// word-aligned bus beats, with the pipeline stalled until the response pulse.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    lsu_bus_ctrl_if.slave lsu
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              beat;
    logic              in_req;
    size_t             req_size;

    logic              we_q;
    size_t             size_q;
    logic [1:0]        off_q;
    logic              split_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata0_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;

    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata0;
    logic [31:0]       load_data;

    assign accept   = lsu.req_valid && (state == IDLE);
    assign req_size = lsu.req_lb ? SZ_B : (lsu.req_lh ? SZ_H : SZ_W);
    assign beat     = (state == REQ1) || (state == WAIT1);
    assign in_req   = (state == REQ0) || (state == REQ1);

    // In WAIT0 the low word is still on the bus, so merge straight from it.
    assign lane_rdata0 = (state == WAIT0) ? lsu.bus_rdata : rdata0_q;

    lsu_lane_align u_lane_align (
        .size       (size_q),
        .off        (off_q),
        .beat       (beat),
        .wdata      (wdata_q),
        .rdata0     (lane_rdata0),
        .rdata1     (lsu.bus_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus beat outputs are driven only while requesting, so they read as zero otherwise.
    always_comb begin
        state_next    = state;
        lsu.bus_req   = in_req;
        lsu.bus_we    = 1'b0;
        lsu.bus_addr  = '0;
        lsu.bus_be    = 4'b0000;
        lsu.bus_wdata = 32'h0;
        lsu.req_ready = (state == IDLE);
        lsu.stall     = (state != IDLE) || lsu.req_valid;
        lsu.rsp_valid = rsp_valid_q;
        lsu.rsp_data  = rsp_data_q;

        if (in_req) begin
            lsu.bus_we    = we_q;
            lsu.bus_addr  = beat ? (addr_q + ADDR_W'(4)) : addr_q;
            lsu.bus_be    = lane_be;
            lsu.bus_wdata = we_q ? lane_wdata : 32'h0;
        end

        case (state)
            IDLE:  if (accept) state_next = REQ0;
            REQ0: begin
                if (lsu.bus_gnt) begin
                    if (!we_q)        state_next = WAIT0;
                    else if (split_q) state_next = REQ1;
                    else              state_next = RESP;
                end
            end
            WAIT0: if (lsu.bus_rvalid) state_next = split_q ? REQ1 : RESP;
            REQ1:  if (lsu.bus_gnt) state_next = we_q ? RESP : WAIT1;
            WAIT1: if (lsu.bus_rvalid) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= SZ_W;
            off_q   <= 2'b00;
            split_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= lsu.req_we;
            size_q  <= req_size;
            off_q   <= lsu.req_addr[1:0];
            split_q <= is_split(req_size, lsu.req_addr[1:0]);
            addr_q  <= {lsu.req_addr[ADDR_W-1:2], 2'b00};
            wdata_q <= lsu.req_wdata;
        end
    end

    // Response is registered on the way into RESP; rsp_data holds until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            if ((state == WAIT0) && lsu.bus_rvalid) begin
                rdata0_q <= lsu.bus_rdata;
            end
            rsp_valid_q <= (state_next == RESP);
            if (state_next == RESP) begin
                rsp_data_q <= we_q ? 32'h0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench: byte-level memory reference model, randomized accesses and bus delays.
module tb_lsu_bus_ctrl;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    logic [7:0]  busMem [logic [31:0]];
    logic [7:0]  refMem [logic [31:0]];
    logic [31:0] beatAddr  [2];
    logic [3:0]  beatBe    [2];
    logic [31:0] beatWdata [2];
    logic [31:0] lastRsp;
    int          lastLat;

    lsu_bus_ctrl_if #(.ADDR_W(32)) lsu ();

    lsu_bus_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (lsu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] initByte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] busByte(input logic [31:0] a);
        return busMem.exists(a) ? busMem[a] : initByte(a);
    endfunction

    function automatic logic [7:0] refByte(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initByte(a);
    endfunction

    function automatic logic [31:0] busWord(input logic [31:0] word);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = busByte(word + 32'(j));
        return w;
    endfunction

    task automatic setWord(input logic [31:0] word, input logic [31:0] data);
        for (int j = 0; j < 4; j++) begin
            busMem[word + 32'(j)] = data[8*j +: 8];
            refMem[word + 32'(j)] = data[8*j +: 8];
        end
    endtask

    // One complete access: accept, each beat with its grant/read delays, response pulse.
    task automatic applyStimulus(input logic we, input logic lb, input logic lh,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int gntDly, input int rvDly);
        int          n;
        int          nBeats;
        int          cycles;
        int          expLat;
        int          guard;
        int          d;
        logic [31:0] expData;
        logic [31:0] word;
        logic [31:0] a;
        logic [3:0]  expBe;

        n       = lb ? 1 : (lh ? 2 : 4);
        nBeats  = (int'(addr[1:0]) + n > 4) ? 2 : 1;
        expData = 32'h0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            expData[8*i +: 8] = refByte(a);
            if (we) refMem[a] = wdata[8*i +: 8];
        end
        expLat = 1;

        @(negedge clk);
        lsu.req_valid = 1'b1;
        lsu.req_we    = we;
        lsu.req_lb    = lb;
        lsu.req_lh    = lh;
        lsu.req_addr  = addr;
        lsu.req_wdata = wdata;
        #1;
        checkOutput("req_ready_idle", lsu.req_ready, 1);
        checkOutput("stall_accept", lsu.stall, 1);
        @(posedge clk);
        cycles = 1;
        @(negedge clk);
        lsu.req_valid = 1'b0;
        lsu.req_we    = 1'($urandom);
        lsu.req_lb    = 1'($urandom);
        lsu.req_addr  = $urandom;
        lsu.req_wdata = $urandom;

        for (int b = 0; b < nBeats; b++) begin
            word = (addr & 32'hFFFF_FFFC) + 32'(4 * b);
            for (int j = 0; j < 4; j++) begin
                a        = word + 32'(j);
                expBe[j] = ((a - addr) < 32'(n));
            end
            expLat += gntDly + 1 + (we ? 0 : rvDly + 1);

            for (int w = 0; w <= gntDly; w++) begin
                #1;
                checkOutput("bus_req", lsu.bus_req, 1);
                checkOutput("bus_addr", lsu.bus_addr, word);
                checkOutput("bus_be", lsu.bus_be, expBe);
                checkOutput("bus_we", lsu.bus_we, we);
                checkOutput("stall_req", lsu.stall, 1);
                if (we) begin
                    for (int j = 0; j < 4; j++) begin
                        if (expBe[j]) begin
                            d = int'(word + 32'(j) - addr);
                            checkOutput("bus_wdata_lane", lsu.bus_wdata[8*j +: 8], wdata[8*d +: 8]);
                        end
                    end
                end
                if (w == gntDly) begin
                    lsu.bus_gnt  = 1'b1;
                    beatAddr[b]  = lsu.bus_addr;
                    beatBe[b]    = lsu.bus_be;
                    beatWdata[b] = lsu.bus_wdata;
                    if (!we && ($urandom_range(0, 1) == 1)) begin
                        lsu.bus_rvalid = 1'b1;
                        lsu.bus_rdata  = $urandom;
                    end
                    if (we) begin
                        for (int j = 0; j < 4; j++)
                            if (lsu.bus_be[j]) busMem[lsu.bus_addr + 32'(j)] = lsu.bus_wdata[8*j +: 8];
                    end
                end
                @(posedge clk);
                cycles++;
                @(negedge clk);
                lsu.bus_gnt    = 1'b0;
                lsu.bus_rvalid = 1'b0;
            end

            if (!we) begin
                for (int w = 0; w <= rvDly; w++) begin
                    #1;
                    checkOutput("bus_req_wait", lsu.bus_req, 0);
                    checkOutput("stall_wait", lsu.stall, 1);
                    if (w == rvDly) begin
                        lsu.bus_rvalid = 1'b1;
                        lsu.bus_rdata  = busWord(word);
                    end else begin
                        lsu.bus_rdata  = $urandom;
                    end
                    @(posedge clk);
                    cycles++;
                    @(negedge clk);
                    lsu.bus_rvalid = 1'b0;
                end
            end
        end

        guard = 0;
        while ((lsu.rsp_valid !== 1'b1) && (guard < 20)) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            guard++;
        end
        checkOutput("rsp_valid", lsu.rsp_valid, 1);
        checkOutput("latency", cycles, expLat);
        checkOutput("rsp_data", lsu.rsp_data, we ? 32'h0 : expData);
        checkOutput("stall_resp", lsu.stall, 1);
        lastRsp = lsu.rsp_data;
        lastLat = cycles;

        @(posedge clk);
        @(negedge clk);
        checkOutput("rsp_single_pulse", lsu.rsp_valid, 0);
        checkOutput("req_ready_after", lsu.req_ready, 1);
        checkOutput("stall_after", lsu.stall, 0);
        checkOutput("bus_req_after", lsu.bus_req, 0);
        checkOutput("rsp_data_hold", lsu.rsp_data, lastRsp);
    endtask

    // Reset lands in WAIT1 of a split load; the late read data must not produce a response.
    task automatic applyResetMidAccess();
        @(negedge clk);
        lsu.req_valid = 1'b1;
        lsu.req_we    = 1'b0;
        lsu.req_lb    = 1'b0;
        lsu.req_lh    = 1'b0;
        lsu.req_addr  = 32'h0000_02FE;
        @(posedge clk);
        @(negedge clk);
        lsu.req_valid = 1'b0;
        lsu.bus_gnt   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lsu.bus_gnt    = 1'b0;
        lsu.bus_rvalid = 1'b1;
        lsu.bus_rdata  = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        lsu.bus_rvalid = 1'b0;
        lsu.bus_gnt    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lsu.bus_gnt = 1'b0;
        #1;
        checkOutput("rst_pre_stall", lsu.stall, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_bus_req", lsu.bus_req, 0);
        checkOutput("rst_req_ready", lsu.req_ready, 1);
        checkOutput("rst_rsp_valid", lsu.rsp_valid, 0);
        checkOutput("rst_rsp_data", lsu.rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        lsu.bus_rvalid = 1'b1;
        lsu.bus_rdata  = 32'h1357_9BDF;
        @(posedge clk);
        @(negedge clk);
        lsu.bus_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("rst_no_rsp", lsu.rsp_valid, 0);
            checkOutput("rst_idle_ready", lsu.req_ready, 1);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int          sel;
        logic        rwe;
        logic [31:0] raddr;

        compared       = 0;
        mismatched     = 0;
        rst            = 1'b1;
        lsu.req_valid  = 1'b0;
        lsu.req_we     = 1'b0;
        lsu.req_lb     = 1'b0;
        lsu.req_lh     = 1'b0;
        lsu.req_addr   = 32'h0;
        lsu.req_wdata  = 32'h0;
        lsu.bus_gnt    = 1'b0;
        lsu.bus_rvalid = 1'b0;
        lsu.bus_rdata  = 32'h0;

        #12;
        checkOutput("reset_req_ready", lsu.req_ready, 1);
        checkOutput("reset_rsp_valid", lsu.rsp_valid, 0);
        checkOutput("reset_rsp_data", lsu.rsp_data, 0);
        checkOutput("reset_stall", lsu.stall, 0);
        checkOutput("reset_bus_req", lsu.bus_req, 0);
        checkOutput("reset_bus_we", lsu.bus_we, 0);
        checkOutput("reset_bus_addr", lsu.bus_addr, 0);
        checkOutput("reset_bus_be", lsu.bus_be, 0);
        checkOutput("reset_bus_wdata", lsu.bus_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] aligned word load");
        setWord(32'h0000_0100, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 0, 0);
        checkOutput("lw_be", beatBe[0], 4'b1111);
        checkOutput("lw_addr", beatAddr[0], 32'h0000_0100);
        checkOutput("lw_data", lastRsp, 32'hDEAD_BEEF);
        checkOutput("lw_latency", lastLat, 3);

        $display("[TB] byte load from top lane");
        setWord(32'h0000_0100, 32'h8011_2233);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 0, 0);
        checkOutput("lb_be", beatBe[0], 4'b1000);
        checkOutput("lb_data", lastRsp, 32'h0000_0080);

        $display("[TB] split word load");
        setWord(32'h0000_01FC, 32'hAABB_CCDD);
        setWord(32'h0000_0200, 32'h1122_3344);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_01FE, 32'h0, 0, 0);
        checkOutput("slw_addr0", beatAddr[0], 32'h0000_01FC);
        checkOutput("slw_be0", beatBe[0], 4'b1100);
        checkOutput("slw_addr1", beatAddr[1], 32'h0000_0200);
        checkOutput("slw_be1", beatBe[1], 4'b0011);
        checkOutput("slw_data", lastRsp, 32'h3344_AABB);
        checkOutput("slw_latency", lastLat, 5);

        $display("[TB] split halfword store across address wrap");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 0, 0);
        checkOutput("ssh_addr0", beatAddr[0], 32'hFFFF_FFFC);
        checkOutput("ssh_be0", beatBe[0], 4'b1000);
        checkOutput("ssh_wdata0", beatWdata[0], 32'h3400_0000);
        checkOutput("ssh_addr1", beatAddr[1], 32'h0000_0000);
        checkOutput("ssh_be1", beatBe[1], 4'b0001);
        checkOutput("ssh_wdata1", beatWdata[1], 32'h0000_0012);
        checkOutput("ssh_latency", lastLat, 3);

        $display("[TB] slow bus: grant after 3 cycles, read data after 2");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0180, 32'h0, 3, 2);

        $display("[TB] reset during second beat of split load");
        applyResetMidAccess();

        $display("[TB] randomized accesses");
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 3);
            rwe = 1'($urandom);
            if ($urandom_range(0, 9) == 0) raddr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           raddr = 32'h0000_1000 + 32'($urandom_range(0, 23));
            applyStimulus(rwe, (sel == 0) || (sel == 3), (sel == 1) || (sel == 3),
                          raddr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
